// File: rtl/loader_pkg.sv
// Shared constants and FSM state type for the instruction loader and the instruction RAM/fetch stage.
package loader_pkg;

   localparam int IRAM_DEPTH    = 1701;
   localparam int IRAM_ADDR_W   = 12;
   localparam int HDR_LEN_BYTES = 2;
   localparam int LEN_W         = 8 * HDR_LEN_BYTES;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_LEN_HI = 4'd1,
      S_LEN_LO = 4'd2,
      S_CHECK  = 4'd3,
      S_DATA   = 4'd4,
      S_WRITE  = 4'd5,
      S_SUM    = 4'd6,
      S_DONE   = 4'd7,
      S_ERROR  = 4'd8
   } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream big-endian into 32-bit words; o_full means the next push completes a word.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_push,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_full
);

   logic [1:0]  r_count;
   logic [31:0] r_word;

   always_ff @(posedge clock) begin
      if (reset || i_clear) begin
         r_count <= '0;
         r_word  <= '0;
      end else if (i_push) begin
         r_count <= r_count + 2'd1;
         r_word  <= {r_word[23:0], i_byte};
      end
   end

   assign o_word = r_word;
   assign o_full = (r_count == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Boot-time loader: length header, big-endian instruction bytes and a mod-256 checksum trailer
// are turned into one-word-at-a-time writes to the instruction RAM.
module instruction_loader
   import loader_pkg::*;
#(
   parameter int DEPTH     = IRAM_DEPTH,
   parameter int ADDR_W    = IRAM_ADDR_W,
   parameter int BASE_ADDR = 0
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [ADDR_W-1:0] i_ram_writing_address,
   output logic [31:0]       i_ram_input,
   output logic              flag_write_i_ram,
   output logic              loading,
   output logic              done,
   output logic              error,
   output logic [3:0]        o_dbg_state
);

   // Handshake: a byte transfers on a posedge where byte_valid && byte_ready; the source
   // holds byte_in stable while byte_valid is high and the loader has not accepted it.

   state_t              r_state;
   state_t              w_next_state;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_word_idx;
   logic [7:0]          r_checksum;

   logic                r_byte_ready;
   logic                r_loading;
   logic                r_done;
   logic                r_error;
   logic                r_wr;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_data;

   logic                w_byte_ready_d;
   logic                w_loading_d;
   logic                w_done_d;
   logic                w_error_d;
   logic                w_wr_d;
   logic [ADDR_W-1:0]   w_addr_d;
   logic [31:0]         w_data_d;

   logic                w_accept;
   logic                w_start_ok;
   logic                w_push;
   logic [31:0]         w_word;
   logic                w_full;
   logic [LEN_W:0]      w_end;

   assign w_accept   = byte_valid && r_byte_ready;
   assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
   assign w_push     = w_accept && (r_state == S_DATA);
   // One extra bit so BASE_ADDR+N cannot wrap before the depth comparison.
   assign w_end      = {1'b0, r_len} + (LEN_W+1)'(BASE_ADDR);

   word_assembler u_word_assembler (
      .clock   (clock),
      .reset   (reset),
      .i_clear (w_start_ok),
      .i_push  (w_push),
      .i_byte  (byte_in),
      .o_word  (w_word),
      .o_full  (w_full)
   );

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: if (start) w_next_state = S_LEN_HI;
         S_LEN_HI: if (w_accept) w_next_state = S_LEN_LO;
         S_LEN_LO: if (w_accept) w_next_state = S_CHECK;
         S_CHECK: begin
            if (r_len == '0)                       w_next_state = S_SUM;
            else if (w_end > (LEN_W+1)'(DEPTH))    w_next_state = S_ERROR;
            else                                   w_next_state = S_DATA;
         end
         S_DATA: if (w_accept && w_full) w_next_state = S_WRITE;
         S_WRITE: begin
            if ((r_word_idx + LEN_W'(1)) == r_len) w_next_state = S_SUM;
            else                                   w_next_state = S_DATA;
         end
         S_SUM: begin
            if (w_accept) w_next_state = (byte_in == r_checksum) ? S_DONE : S_ERROR;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they track the state with no lag.
   always_comb begin
      w_byte_ready_d = (w_next_state == S_LEN_HI) || (w_next_state == S_LEN_LO) ||
                       (w_next_state == S_DATA)   || (w_next_state == S_SUM);
      w_loading_d    = (w_next_state == S_LEN_HI) || (w_next_state == S_LEN_LO) ||
                       (w_next_state == S_CHECK)  || (w_next_state == S_DATA)   ||
                       (w_next_state == S_WRITE)  || (w_next_state == S_SUM);
      w_done_d       = (w_next_state == S_DONE);
      w_error_d      = (w_next_state == S_ERROR);
      w_wr_d         = (w_next_state == S_WRITE);
      w_addr_d       = r_addr;
      w_data_d       = r_data;
      if (w_next_state == S_WRITE && r_state == S_DATA) begin
         w_addr_d = r_word_idx[ADDR_W-1:0] + ADDR_W'(BASE_ADDR);
         w_data_d = {w_word[23:0], byte_in};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_byte_ready <= 1'b0;
         r_loading    <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_wr         <= 1'b0;
         r_addr       <= '0;
         r_data       <= '0;
      end else begin
         r_byte_ready <= w_byte_ready_d;
         r_loading    <= w_loading_d;
         r_done       <= w_done_d;
         r_error      <= w_error_d;
         r_wr         <= w_wr_d;
         r_addr       <= w_addr_d;
         r_data       <= w_data_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_len      <= '0;
         r_word_idx <= '0;
         r_checksum <= '0;
      end else if (w_start_ok) begin
         r_len      <= '0;
         r_word_idx <= '0;
         r_checksum <= '0;
      end else begin
         case (r_state)
            S_LEN_HI: if (w_accept) r_len[LEN_W-1:8] <= byte_in;
            S_LEN_LO: if (w_accept) r_len[7:0]       <= byte_in;
            S_DATA:   if (w_accept) r_checksum       <= r_checksum + byte_in;
            S_WRITE:  r_word_idx <= r_word_idx + LEN_W'(1);
            default: ;
         endcase
      end
   end

   assign byte_ready            = r_byte_ready;
   assign loading               = r_loading;
   assign done                  = r_done;
   assign error                 = r_error;
   assign flag_write_i_ram      = r_wr;
   assign i_ram_writing_address = r_addr;
   assign i_ram_input           = r_data;
   assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed and randomized load sequences for instruction_loader, checked against a byte-stream
// reference model and a log of RAM write pulses captured at the RAM's negedge sample point.
module tb_instruction_loader;

   localparam int DEPTH = 1701;
   localparam int AW    = 12;
   localparam int BASE  = 0;

   logic          clock;
   logic          reset;
   logic          start;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          wr_en;
   logic          loading;
   logic          done;
   logic          error;
   logic [3:0]    dbg_state;

   instruction_loader #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .start                 (start),
      .byte_in               (byte_in),
      .byte_valid            (byte_valid),
      .byte_ready            (byte_ready),
      .i_ram_writing_address (wr_addr),
      .i_ram_input           (wr_data),
      .flag_write_i_ram      (wr_en),
      .loading               (loading),
      .done                  (done),
      .error                 (error),
      .o_dbg_state           (dbg_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [7:0]     tx_q[$];
   logic [31:0]    img[$];
   logic [AW+31:0] exp_q[$];
   logic [AW+31:0] got_q[$];
   int n_checks  = 0;
   int n_fail    = 0;
   int n_bad_pls = 0;
   logic prev_wr = 1'b0;

   // RAM-side monitor: a write must be a lone one-cycle pulse with byte_ready low.
   always @(negedge clock) begin
      if (wr_en) begin
         got_q.push_back({wr_addr, wr_data});
         if (prev_wr || byte_ready) n_bad_pls++;
      end
      prev_wr = wr_en;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: header = N big-endian, data = words big-endian, trailer = mod-256 byte sum.
   task automatic build_stream(input bit bad_sum);
      int unsigned sum;
      logic [31:0] w;
      logic [15:0] n;
      sum = 0;
      n = 16'(img.size());
      tx_q.delete();
      tx_q.push_back(n[15:8]);
      tx_q.push_back(n[7:0]);
      for (int i = 0; i < img.size(); i++) begin
         w = img[i];
         for (int b = 3; b >= 0; b--) begin
            tx_q.push_back(w[8*b +: 8]);
            sum = sum + 32'(w[8*b +: 8]);
         end
         exp_q.push_back({AW'(BASE + i), w});
      end
      tx_q.push_back(bad_sum ? 8'(sum + 1) : 8'(sum));
   endtask

   task automatic random_image(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_loading"}, 64'(loading), 64'(1));
      check({tag, "_ready"}, 64'(byte_ready), 64'(1));
   endtask

   task automatic drive(input int stall_pct, input int start_at);
      int   guard;
      int   k;
      logic rdy;
      guard = 0;
      k = 0;
      while (tx_q.size() > 0 && guard < 12000) begin
         byte_valid = ($urandom_range(99) >= stall_pct);
         byte_in    = byte_valid ? tx_q[0] : 8'($urandom);
         start      = (k == start_at);
         rdy        = byte_ready;
         tick();
         if (byte_valid && rdy) begin
            void'(tx_q.pop_front());
            k++;
         end
         guard++;
      end
      byte_valid = 1'b0;
      start      = 1'b0;
      check("stream_drained", 64'(tx_q.size()), 64'(0));
      tx_q.delete();
   endtask

   task automatic finish_check(input string tag, input bit exp_done);
      int n;
      check({tag, "_done"}, 64'(done), 64'(exp_done));
      check({tag, "_error"}, 64'(error), 64'(!exp_done));
      check({tag, "_loading"}, 64'(loading), 64'(0));
      check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
      check({tag, "_pulse_shape"}, 64'(n_bad_pls), 64'(0));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b1;
      byte_valid = 1'b1;
      byte_in = 8'h00;
      repeat (3) tick();
      check("rst_ready", 64'(byte_ready), 64'(0));
      check("rst_wr", 64'(wr_en), 64'(0));
      check("rst_addr", 64'(wr_addr), 64'(0));
      check("rst_data", 64'(wr_data), 64'(0));
      check("rst_loading", 64'(loading), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_error", 64'(error), 64'(0));
      reset = 1'b0;
      start = 1'b0;
      byte_valid = 1'b0;
      tick();
      check("idle_loading", 64'(loading), 64'(0));

      // Nominal two-word image, no stalls.
      img = '{32'hDEADBEEF, 32'h01234567};
      build_stream(1'b0);
      do_start("nom_start");
      drive(0, -1);
      finish_check("nominal", 1'b1);

      // Same image, corrupted trailer: words still land, load ends in error.
      build_stream(1'b1);
      do_start("bad_start");
      drive(0, -1);
      finish_check("bad_sum", 1'b0);

      // Zero-length images.
      img.delete();
      build_stream(1'b0);
      do_start("zero_start");
      drive(0, -1);
      finish_check("zero_ok", 1'b1);
      build_stream(1'b1);
      do_start("zero_bad_start");
      drive(0, -1);
      finish_check("zero_bad", 1'b0);

      // Length one past capacity: rejected right after the header, nothing written.
      tx_q = '{8'(DEPTH + 1 >> 8), 8'(DEPTH + 1)};
      do_start("ovf_start");
      drive(0, -1);
      check("ovf_in_check", 64'(loading), 64'(1));
      tick();
      finish_check("overflow", 1'b0);

      // Randomized images with stalls and stray start pulses mid-load.
      for (int r = 0; r < 5; r++) begin
         random_image($urandom_range(1, 6));
         build_stream(r == 4);
         do_start("rnd_start");
         drive(40, $urandom_range(0, 8));
         finish_check("random", r != 4);
      end

      // Reset after two data bytes, then a clean reload from BASE.
      tx_q = '{8'h00, 8'h02, 8'hDE, 8'hAD};
      do_start("mid_start");
      drive(0, -1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_ready", 64'(byte_ready), 64'(0));
      check("mid_rst_loading", 64'(loading), 64'(0));
      check("mid_rst_wr", 64'(wr_en), 64'(0));
      check("mid_rst_addr", 64'(wr_addr), 64'(0));
      check("mid_rst_data", 64'(wr_data), 64'(0));
      check("mid_rst_done_err", 64'({done, error}), 64'(0));
      check("mid_rst_nowrites", 64'(got_q.size()), 64'(0));
      img = '{32'hDEADBEEF, 32'h01234567};
      build_stream(1'b0);
      do_start("reload_start");
      drive(20, -1);
      finish_check("reload", 1'b1);

      // Image that exactly fills the RAM, valid held high through CHECK/WRITE.
      random_image(DEPTH);
      build_stream(1'b0);
      do_start("full_start");
      drive(0, -1);
      finish_check("full", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
